// File: rtl/sample_sequencer_pkg.sv
// Shared encodings for the sample sequencer: FSM states, channel-mode codes, sample width.
// Counter width covers the full PROC_LAT range (1..15).
package sample_sequencer_pkg;

  localparam int SMP_W = 10;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_PROC = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CM_CH0  = 2'b00,
    CM_CH1  = 2'b01,
    CM_ALT  = 2'b10,
    CM_HOLD = 2'b11
  } ch_mode_t;

endpackage

// File: rtl/sample_sequencer_counter.sv
// Loadable down-counter that stops at zero; used for processing latency and the conversion watchdog.
// zero_o reflects the registered count, so a load of N gives N+1 cycles before zero is seen.
module seq_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sample_sequencer.sv
// Tick-driven ADC -> processor -> DAC sequencer; all strobes are registered one-cycle pulses.
// Optional conversion watchdog (wdog_err, err_count) is built when SEQ_WDOG_EN is defined.
module sample_sequencer
  import sample_sequencer_pkg::*;
#(
  parameter int PROC_LAT = 2,
  parameter int TIMEOUT  = 2000
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic [1:0]       ch_mode,
  output logic             adc_start,
  output logic             adc_channel,
  input  logic             adc_valid,
  input  logic [SMP_W-1:0] adc_data,
  output logic [SMP_W-1:0] proc_in,
  output logic             proc_valid,
  input  logic [SMP_W-1:0] proc_out,
  output logic [SMP_W-1:0] dac_data,
  output logic             dac_ch,
  output logic             dac_start,
  output logic             busy,
  output logic             overrun
`ifdef SEQ_WDOG_EN
  ,
  output logic             wdog_err,
  output logic [7:0]       err_count
`endif
);

  if (TIMEOUT < 2 || PROC_LAT < 1 || PROC_LAT > 15) begin : g_bad_cfg
  end

  state_t state_q, state_d;

  logic             tick_acc, conv_done, lat_zero, timeout;
  logic             chan_q, chan_d, tgl_q, tgl_d;
  logic             adc_start_q, adc_start_d;
  logic             proc_valid_q, proc_valid_d;
  logic             dac_start_q, dac_start_d;
  logic             overrun_q, overrun_d;
  logic [SMP_W-1:0] proc_in_q, proc_in_d;
  logic [SMP_W-1:0] dac_data_q, dac_data_d;
  logic             dac_ch_q, dac_ch_d;

  assign tick_acc  = tick && (state_q == ST_IDLE);
  assign conv_done = adc_valid && (state_q == ST_CONV);

  seq_counter #(.W(CNT_W)) u_lat_cnt (
    .clk_i      (sysclk),
    .rst_ni     (reset_n),
    .load_i     (conv_done),
    .load_val_i (CNT_W'(PROC_LAT)),
    .en_i       (state_q == ST_PROC),
    .zero_o     (lat_zero)
  );

`ifdef SEQ_WDOG_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic       wd_zero;
  logic       wdog_err_q;
  logic [7:0] err_cnt_q;

  // Loaded with TIMEOUT-1 so the last allowed CONV cycle is the TIMEOUT-th one.
  seq_counter #(.W(TW)) u_wdog_cnt (
    .clk_i      (sysclk),
    .rst_ni     (reset_n),
    .load_i     (tick_acc),
    .load_val_i (TW'(TIMEOUT - 1)),
    .en_i       (state_q == ST_CONV),
    .zero_o     (wd_zero)
  );

  assign timeout = (state_q == ST_CONV) && !adc_valid && wd_zero;

  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      wdog_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      wdog_err_q <= timeout;
      if (timeout && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign wdog_err  = wdog_err_q;
  assign err_count = err_cnt_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (tick) state_d = ST_CONV;
      ST_CONV: begin
        if (adc_valid)    state_d = ST_PROC;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_PROC: if (lat_zero) state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    adc_start_d  = tick_acc;
    proc_valid_d = conv_done;
    dac_start_d  = (state_q == ST_OUT);
    overrun_d    = tick && (state_q != ST_IDLE);
    chan_d       = chan_q;
    tgl_d        = tgl_q;
    proc_in_d    = conv_done ? adc_data : proc_in_q;
    dac_data_d   = dac_data_q;
    dac_ch_d     = dac_ch_q;
    if (tick_acc) begin
      case (ch_mode_t'(ch_mode))
        CM_CH0:  chan_d = 1'b0;
        CM_CH1:  chan_d = 1'b1;
        CM_ALT: begin
          chan_d = tgl_q;
          tgl_d  = ~tgl_q;
        end
        default: chan_d = chan_q;
      endcase
    end
    if ((state_q == ST_PROC) && lat_zero) begin
      dac_data_d = proc_out;
      dac_ch_d   = chan_q;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      adc_start_q  <= 1'b0;
      proc_valid_q <= 1'b0;
      dac_start_q  <= 1'b0;
      overrun_q    <= 1'b0;
      chan_q       <= 1'b0;
      tgl_q        <= 1'b0;
      proc_in_q    <= '0;
      dac_data_q   <= '0;
      dac_ch_q     <= 1'b0;
    end else begin
      adc_start_q  <= adc_start_d;
      proc_valid_q <= proc_valid_d;
      dac_start_q  <= dac_start_d;
      overrun_q    <= overrun_d;
      chan_q       <= chan_d;
      tgl_q        <= tgl_d;
      proc_in_q    <= proc_in_d;
      dac_data_q   <= dac_data_d;
      dac_ch_q     <= dac_ch_d;
    end
  end

  assign adc_start   = adc_start_q;
  assign adc_channel = chan_q;
  assign proc_valid  = proc_valid_q;
  assign proc_in     = proc_in_q;
  assign dac_start   = dac_start_q;
  assign dac_data    = dac_data_q;
  assign dac_ch      = dac_ch_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench for sample_sequencer; inputs driven and outputs sampled 1 time unit after posedge.
// Watchdog scenarios are included when SEQ_WDOG_EN is defined.
module tb_sample_sequencer;

  logic       sysclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] ch_mode = 2'b00;
  logic       adc_valid = 1'b0;
  logic [9:0] adc_data = '0;
  logic [9:0] proc_out = '0;
  logic       adc_start, adc_channel, proc_valid, dac_ch, dac_start, busy, overrun;
  logic [9:0] proc_in, dac_data;
`ifdef SEQ_WDOG_EN
  logic       wdog_err;
  logic [7:0] err_count;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #10 sysclk = ~sysclk;

  sample_sequencer #(.PROC_LAT(2), .TIMEOUT(50)) dut (
    .sysclk      (sysclk),
    .reset_n     (reset_n),
    .tick        (tick),
    .ch_mode     (ch_mode),
    .adc_start   (adc_start),
    .adc_channel (adc_channel),
    .adc_valid   (adc_valid),
    .adc_data    (adc_data),
    .proc_in     (proc_in),
    .proc_valid  (proc_valid),
    .proc_out    (proc_out),
    .dac_data    (dac_data),
    .dac_ch      (dac_ch),
    .dac_start   (dac_start),
    .busy        (busy),
    .overrun     (overrun)
`ifdef SEQ_WDOG_EN
    ,
    .wdog_err    (wdog_err),
    .err_count   (err_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Returns in the first cycle after the tick was sampled.
  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // Starting in the cycle after an accepted tick: return adc_valid dly cycles after
  // the tick, then wait for dac_start. lat is tick-to-dac_start in cycles.
  task automatic conv_seq(input logic [9:0] d, input int dly, output int lat);
    int n;
    for (int i = 1; i < dly; i++) step();
    adc_valid = 1'b1;
    adc_data  = d;
    step();
    adc_valid = 1'b0;
    n = dly;
    while (!dac_start && n < dly + 40) begin
      step();
      n++;
    end
    lat = n + 1;
  endtask

  initial begin
    int lat;
    int ndac;
    int n;

    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_adc_start", adc_start, 0);
    chk("rst_dac_data", dac_data, 0);
    chk("rst_dac_ch", dac_ch, 0);
    chk("rst_proc_in", proc_in, 0);
    chk("rst_strobes", {proc_valid, dac_start, overrun}, 0);
`ifdef SEQ_WDOG_EN
    chk("rst_err_count", err_count, 0);
`endif

    // CH1 only, 20-cycle conversion
    ch_mode  = 2'b01;
    proc_out = 10'h15A;
    do_tick();
    chk("t1_adc_start", adc_start, 1);
    chk("t1_adc_channel", adc_channel, 1);
    chk("t1_busy", busy, 1);
    for (int i = 1; i < 20; i++) step();
    adc_valid = 1'b1;
    adc_data  = 10'h2A5;
    step();
    adc_valid = 1'b0;
    chk("t1_proc_valid", proc_valid, 1);
    chk("t1_proc_in", proc_in, 10'h2A5);
    n = 20;
    while (!dac_start && n < 60) begin
      step();
      n++;
    end
    chk("t1_latency", n + 1, 25);
    chk("t1_dac_data", dac_data, 10'h15A);
    chk("t1_dac_ch", dac_ch, 1);
    step();
    chk("t1_dac_start_pulse", dac_start, 0);
    chk("t1_idle", busy, 0);

    // Alternate mode from reset: 0,1,0,1
    do_reset();
    ch_mode = 2'b10;
    for (int k = 0; k < 4; k++) begin
      proc_out = 10'(10'h100 + k);
      do_tick();
      chk("alt_adc_channel", adc_channel, k % 2);
      conv_seq(10'(k), 5, lat);
      chk("alt_latency", lat, 10);
      chk("alt_dac_ch", dac_ch, k % 2);
      chk("alt_dac_data", dac_data, 10'h100 + k);
    end

    // Tick during PROC and during OUT are dropped
    step();
    ch_mode  = 2'b00;
    proc_out = 10'h321;
    do_tick();
    ch_mode  = 2'b01;
    step();
    step();
    adc_valid = 1'b1;
    adc_data  = 10'h0F0;
    step();
    adc_valid = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("ovr_proc_pulse", overrun, 1);
    chk("ovr_proc_no_start", adc_start, 0);
    step();
    step();
    chk("ovr_out_busy", busy, 1);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("ovr_out_pulse", overrun, 1);
    chk("ovr_out_no_start", adc_start, 0);
    ndac = dac_start ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dac_start) ndac++;
    end
    chk("ovr_single_dac_start", ndac, 1);
    chk("ovr_dac_data", dac_data, 10'h321);
    chk("ovr_dac_ch", dac_ch, 0);
    proc_out = 10'h0AB;
    do_tick();
    chk("ovr_next_accept", adc_start, 1);
    chk("ovr_next_channel", adc_channel, 1);
    conv_seq(10'h011, 4, lat);
    chk("ovr_next_latency", lat, 9);
    chk("ovr_next_dac_data", dac_data, 10'h0AB);

    // Reset during CONV
    do_reset();
    ch_mode  = 2'b10;
    proc_out = 10'h3C3;
    do_tick();
    conv_seq(10'h001, 3, lat);
    chk("rc_first_dac_data", dac_data, 10'h3C3);
    step();
    do_tick();
    chk("rc_second_channel", adc_channel, 1);
    step();
    step();
    do_reset();
    chk("rc_busy", busy, 0);
    chk("rc_dac_data", dac_data, 0);
    chk("rc_dac_ch", dac_ch, 0);
    ndac = 0;
    for (int i = 0; i < 10; i++) begin
      adc_valid = (i == 2);
      step();
      if (dac_start) ndac++;
    end
    adc_valid = 1'b0;
    chk("rc_no_dac_start", ndac, 0);
    do_tick();
    chk("rc_next_channel", adc_channel, 0);
    conv_seq(10'h002, 3, lat);
    step();

    // adc_valid while IDLE is ignored
    adc_valid = 1'b1;
    adc_data  = 10'h3FF;
    step();
    adc_valid = 1'b0;
    chk("iv_proc_valid", proc_valid, 0);
    chk("iv_busy", busy, 0);
    chk("iv_proc_in", proc_in, 10'h002);
    step();
    chk("iv_still_idle", {busy, proc_valid}, 0);

`ifdef SEQ_WDOG_EN
    ch_mode = 2'b00;
    do_tick();
    n = 0;
    while (!wdog_err && n < 200) begin
      step();
      n++;
    end
    chk("wd_cycle", n, 50);
    chk("wd_err_count", err_count, 1);
    chk("wd_idle", busy, 0);
    chk("wd_no_dac_start", dac_start, 0);
    step();
    chk("wd_err_pulse", wdog_err, 0);
    for (int k = 1; k < 256; k++) begin
      do_tick();
      n = 0;
      while (!wdog_err && n < 200) begin
        step();
        n++;
      end
      if (n >= 200) chk("wd_loop_timeout", n, 50);
    end
    chk("wd_err_count_255", err_count, 255);
    do_tick();
    n = 0;
    while (!wdog_err && n < 200) begin
      step();
      n++;
    end
    chk("wd_err_count_sat", err_count, 255);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
